// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WR write ports, NUM_RD registered read ports and a busy scoreboard.
// Define SCOREBOARD_BYPASS_EN for write-to-read forwarding; the default build is read-before-write.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_addr,
    output logic [DEPTH-1:0]           busy_vec,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic [DEPTH-1:0]         wr_hit, set_hit;
    logic [DATA_W-1:0]        wr_val [DEPTH];

    // Per-register write decode; ascending port scan lets the highest index win.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*DATA_W +: DATA_W];
                end
            end
            set_hit[r] = set_en && (set_addr == ADDR_W'(r));
        end
        if (ZERO_REG) begin
            wr_hit[0]  = 1'b0;
            set_hit[0] = 1'b0;
        end
    end

    // A set in the same cycle as a completing write wins: the new producer issued later.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
            busy_d[r] = set_hit[r] | (busy_q[r] & ~wr_hit[r]);
        end
    end

    // Read mux scans only valid addresses, so out-of-range reads fall through to zero.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
`ifdef SCOREBOARD_BYPASS_EN
                    rd_data_d[k*DATA_W +: DATA_W] = wr_hit[r] ? wr_val[r] : regs_q[r];
                    rd_busy_d[k]                  = wr_hit[r] ? set_hit[r] : busy_q[r];
`else
                    rd_data_d[k*DATA_W +: DATA_W] = regs_q[r];
                    rd_busy_d[k]                  = busy_q[r];
`endif
                end
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (dbg_addr == ADDR_W'(r)) begin
                dbg_data = regs_q[r];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters and hand-computed expectations.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             set_en;
    logic [AW-1:0]    set_addr;
    logic [31:0]      busy_vec;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_data;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_mp dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .set_en   (set_en),
        .set_addr (set_addr),
        .busy_vec (busy_vec),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        set_en = 1'b0;
    endtask

    task automatic put_wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]            = 1'b1;
        wr_addr[port*AW +: AW] = AW'(addr);
        wr_data[port*DW +: DW] = data;
    endtask

    task automatic put_rd(input int port, input int addr);
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    function automatic logic [31:0] rdat(input int port);
        return rd_data[port*DW +: DW];
    endfunction

    initial begin
        reset    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        set_en   = 1'b0;
        set_addr = '0;
        dbg_addr = '0;
        tick();
        tick();
        reset = 1'b1;
        check_eq("reset_rd_data0", rdat(0), 32'h0);
        check_eq("reset_rd_busy", {28'h0, rd_busy}, 32'h0);
        check_eq("reset_busy_vec", busy_vec, 32'h0);

        // Basic write, registered read and debug read
        put_wr(0, 3, 32'hDEAD_BEEF);
        tick();
        idle();
        put_rd(2, 3);
        dbg_addr = 5'd3;
        #1;
        check_eq("dbg_reg3", dbg_data, 32'hDEAD_BEEF);
        tick();
        check_eq("rd2_reg3", rdat(2), 32'hDEAD_BEEF);
        check_eq("rd2_busy_reg3", {31'h0, rd_busy[2]}, 32'h0);

        // Same-address collision: port1 wins
        put_wr(0, 7, 32'h11);
        put_wr(1, 7, 32'h22);
        tick();
        idle();
        dbg_addr = 5'd7;
        #1;
        check_eq("collide_reg7", dbg_data, 32'h22);

        // Different addresses in the same cycle
        put_wr(0, 10, 32'h1010);
        put_wr(1, 11, 32'h1111);
        tick();
        idle();
        put_rd(0, 3);
        put_rd(1, 7);
        put_rd(2, 10);
        put_rd(3, 11);
        tick();
        check_eq("multi_rd0", rdat(0), 32'hDEAD_BEEF);
        check_eq("multi_rd1", rdat(1), 32'h22);
        check_eq("multi_rd2", rdat(2), 32'h1010);
        check_eq("multi_rd3", rdat(3), 32'h1111);

        // Scoreboard set, set-beats-clear, then clear
        set_en   = 1'b1;
        set_addr = 5'd5;
        tick();
        idle();
        check_eq("busy_set5", busy_vec, 32'h0000_0020);
        put_rd(0, 5);
        tick();
        check_eq("rd_busy_reg5", {31'h0, rd_busy[0]}, 32'h1);
        put_wr(0, 5, 32'h55);
        set_en   = 1'b1;
        set_addr = 5'd5;
        tick();
        idle();
        check_eq("busy_set_wins", busy_vec, 32'h0000_0020);
        put_wr(1, 5, 32'h56);
        tick();
        idle();
        check_eq("busy_clear5", busy_vec, 32'h0);

        // Zero register ignores writes and sets
        put_wr(1, 0, 32'hFFFF_FFFF);
        set_en   = 1'b1;
        set_addr = 5'd0;
        put_rd(1, 0);
        tick();
        idle();
        tick();
        check_eq("zero_rd_data", rdat(1), 32'h0);
        check_eq("zero_rd_busy", {31'h0, rd_busy[1]}, 32'h0);
        check_eq("zero_busy_vec", busy_vec, 32'h0);
        dbg_addr = 5'd0;
        #1;
        check_eq("zero_dbg", dbg_data, 32'h0);

        // Read during write to the same address
        put_wr(0, 9, 32'hA);
        tick();
        idle();
        put_rd(3, 9);
        put_wr(0, 9, 32'hB);
        tick();
        idle();
`ifdef SCOREBOARD_BYPASS_EN
        check_eq("rdw_reg9", rdat(3), 32'hB);
`else
        check_eq("rdw_reg9", rdat(3), 32'hA);
`endif
        tick();
        check_eq("after_rdw_reg9", rdat(3), 32'hB);

        // Load and mark regs 1..4, then reset mid-operation
        put_wr(0, 1, 32'h101);
        put_wr(1, 2, 32'h202);
        set_en   = 1'b1;
        set_addr = 5'd1;
        tick();
        put_wr(0, 3, 32'h303);
        put_wr(1, 4, 32'h404);
        set_addr = 5'd2;
        tick();
        idle();
        set_en = 1'b1;
        set_addr = 5'd3;
        tick();
        set_addr = 5'd4;
        tick();
        idle();
        check_eq("pre_reset_busy", busy_vec, 32'h0000_001E);
        put_rd(0, 1);
        put_rd(1, 2);
        put_rd(2, 3);
        put_rd(3, 4);
        tick();
        check_eq("pre_reset_rd3", rdat(3), 32'h404);
        reset = 1'b0;
        put_wr(0, 6, 32'h666);
        set_en   = 1'b1;
        set_addr = 5'd6;
        tick();
        reset = 1'b1;
        idle();
        check_eq("post_reset_busy", busy_vec, 32'h0);
        check_eq("post_reset_rd0", rdat(0), 32'h0);
        check_eq("post_reset_rd3", rdat(3), 32'h0);
        check_eq("post_reset_rd_busy", {28'h0, rd_busy}, 32'h0);
        dbg_addr = 5'd4;
        #1;
        check_eq("post_reset_dbg4", dbg_data, 32'h0);
        dbg_addr = 5'd6;
        #1;
        check_eq("post_reset_dbg6", dbg_data, 32'h0);

        put_wr(1, 2, 32'h77);
        tick();
        idle();
        dbg_addr = 5'd2;
        #1;
        check_eq("post_reset_write2", dbg_data, 32'h77);
        tick();
        check_eq("post_reset_rd1", rdat(1), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
